// File: rtl/bp_fe_bht_update_queue.sv
// In-order BHT update queue. Each issued prediction's history metadata and
// predicted direction is queued; in-order resolutions pop the head and produce
// a registered BHT training write. A mispredicted resolution or flush_i squashes
// every younger (wrong-path) entry.
module bp_fe_bht_update_queue #(
    parameter int global_history_length_p = 8,
    parameter int queue_els_p             = 8,
    localparam int ptr_width_lp           = $clog2(queue_els_p),
    localparam int count_width_lp         = $clog2(queue_els_p + 1)
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               pred_v_i,
    input  logic [global_history_length_p-1:0] pred_history_i,
    input  logic                               pred_taken_i,
    output logic                               pred_ready_o,
    input  logic                               res_v_i,
    input  logic                               res_taken_i,
    output logic                               res_ready_o,
    input  logic                               flush_i,
    output logic                               w_v_o,
    output logic [global_history_length_p-1:0] history_w_o,
    output logic                               actual_o,
    output logic                               correct_o,
    output logic [count_width_lp-1:0]          count_o
);

    typedef struct packed {
        logic [global_history_length_p-1:0] history;
        logic                               taken;
    } entry_s;

    entry_s                             mem_q [queue_els_p];
    entry_s                             mem_d [queue_els_p];
    logic [ptr_width_lp-1:0]            rptr_q, rptr_d;
    logic [ptr_width_lp-1:0]            wptr_q, wptr_d;
    logic [count_width_lp-1:0]          count_q, count_d;
    logic                               w_v_q, w_v_d;
    logic [global_history_length_p-1:0] history_w_q, history_w_d;
    logic                               actual_q, actual_d;
    logic                               correct_q, correct_d;

    logic   full, empty, deq, enq, correct, squash;
    entry_s head;

    // Ready flags come from registered occupancy only, so no input reaches an output.
    assign full         = (count_q == count_width_lp'(queue_els_p));
    assign empty        = (count_q == '0);
    assign pred_ready_o = ~full;
    assign res_ready_o  = ~empty;
    assign count_o      = count_q;
    assign w_v_o        = w_v_q;
    assign history_w_o  = history_w_q;
    assign actual_o     = actual_q;
    assign correct_o    = correct_q;

    // Accept/squash decisions; a full queue rejects even when a dequeue frees a slot.
    always_comb begin
        head    = mem_q[rptr_q];
        deq     = res_v_i & ~empty;
        correct = (head.taken == res_taken_i);
        squash  = flush_i | (deq & ~correct);
        enq     = pred_v_i & ~full & ~squash;
    end

    // Next-state for storage, pointers, occupancy and the registered write port.
    always_comb begin
        mem_d       = mem_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        w_v_d       = deq;
        history_w_d = history_w_q;
        actual_d    = actual_q;
        correct_d   = correct_q;

        if (deq) begin
            history_w_d = head.history;
            actual_d    = res_taken_i;
            correct_d   = correct;
        end

        if (enq) begin
            mem_d[wptr_q] = '{history: pred_history_i, taken: pred_taken_i};
        end

        if (squash) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (deq) rptr_d = rptr_q + ptr_width_lp'(1);
            if (enq) wptr_d = wptr_q + ptr_width_lp'(1);
            if (enq && !deq)      count_d = count_q + count_width_lp'(1);
            else if (deq && !enq) count_d = count_q - count_width_lp'(1);
        end
    end

    // State registers; reset discards all entries and any pending write.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < queue_els_p; i++) mem_q[i] <= '0;
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            w_v_q       <= 1'b0;
            history_w_q <= '0;
            actual_q    <= 1'b0;
            correct_q   <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            w_v_q       <= w_v_d;
            history_w_q <= history_w_d;
            actual_q    <= actual_d;
            correct_q   <= correct_d;
        end
    end

endmodule
